sbd_fifo: RTL and testbench



---
 rtl/sbd_fifo.sv | 124 ++++++++++++
 tb/tb_sbd_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sbd_fifo.sv
// Scoreboard FIFO between issuer and committer: two-wide in-order enqueue,
// two-wide peek/dequeue at the head, and a synchronous flush for commit errors.

package sbd_fifo_pkg;

    typedef struct packed {
        logic [4:0]  pl;
        logic [31:0] pc;
    } sbd_fifo_t;

endpackage

module sbd_fifo
    import sbd_fifo_pkg::*;
#(
    parameter int Depth = 8,
    parameter int CntW  = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [1:0]      wr_valid_i,
    input  sbd_fifo_t       wr_data0_i,
    input  sbd_fifo_t       wr_data1_i,
    output logic [1:0]      wr_rdy_o,
    output logic [1:0]      rd_valid_o,
    output sbd_fifo_t       rd_data0_o,
    output sbd_fifo_t       rd_data1_o,
    input  logic [1:0]      rd_rdy_i,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int PtrW = $clog2(Depth);

    sbd_fifo_t        storage_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;

    logic [CntW-1:0]  free_cnt;
    logic [1:0]       nw;
    logic [1:0]       nr;
    logic [CntW-1:0]  count_d;
    logic [PtrW-1:0]  wr_ptr_p1;
    logic [PtrW-1:0]  rd_ptr_p1;

    // Handshake flags depend only on the registered occupancy, so there is no
    // combinational path from either side's request to the other side's flag.
    always_comb begin
        free_cnt      = CntW'(Depth) - count_q;
        wr_rdy_o[0]   = (free_cnt >= CntW'(1));
        wr_rdy_o[1]   = (free_cnt >= CntW'(2));
        rd_valid_o[0] = (count_q >= CntW'(1));
        rd_valid_o[1] = (count_q >= CntW'(2));
    end

    always_comb begin
        nw = 2'd0;
        if (wr_valid_i == 2'b11 && wr_rdy_o[1]) begin
            nw = 2'd2;
        end else if (wr_valid_i[0] && wr_rdy_o[0]) begin
            nw = 2'd1;
        end

        nr = 2'd0;
        if (rd_rdy_i == 2'b11 && rd_valid_o[1]) begin
            nr = 2'd2;
        end else if (rd_rdy_i[0] && rd_valid_o[0]) begin
            nr = 2'd1;
        end

        count_d   = count_q + CntW'(nw) - CntW'(nr);
        wr_ptr_p1 = wr_ptr_q + PtrW'(1);
        rd_ptr_p1 = rd_ptr_q + PtrW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + PtrW'(nr);
            wr_ptr_q <= wr_ptr_q + PtrW'(nw);
            count_q  <= count_d;
        end
    end

    // Flush leaves the array contents alone; only the pointers are rewound.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                storage_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (nw != 2'd0) begin
                storage_q[wr_ptr_q] <= wr_data0_i;
            end
            if (nw == 2'd2) begin
                storage_q[wr_ptr_p1] <= wr_data1_i;
            end
        end
    end

    always_comb begin
        rd_data0_o = storage_q[rd_ptr_q];
        rd_data1_o = storage_q[rd_ptr_p1];
        count_o    = count_q;
        empty_o    = (count_q == '0);
        full_o     = (count_q == CntW'(Depth));
    end

    assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CntW'(Depth));

    assert property (@(posedge clk_i) disable iff (rst_i) wr_valid_i != 2'b10)
        else $warning("sbd_fifo: wr_valid_i[1] without wr_valid_i[0], request ignored");

endmodule

// File: tb/tb_sbd_fifo.sv
// Directed bench for sbd_fifo: a queue-based model checked every cycle, plus
// literal expectations at the key points of each scenario.

module tb_sbd_fifo;
    import sbd_fifo_pkg::*;

    localparam int Depth = 8;
    localparam int CntW  = $clog2(Depth) + 1;

    logic            clk;
    logic            rst;
    logic            flush;
    logic [1:0]      wr_valid;
    sbd_fifo_t       wr_data0;
    sbd_fifo_t       wr_data1;
    logic [1:0]      wr_rdy;
    logic [1:0]      rd_valid;
    sbd_fifo_t       rd_data0;
    sbd_fifo_t       rd_data1;
    logic [1:0]      rd_rdy;
    logic [CntW-1:0] count;
    logic            empty;
    logic            full;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 0;
    sbd_fifo_t model_q[$];

    sbd_fifo #(.Depth(Depth)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .wr_valid_i (wr_valid),
        .wr_data0_i (wr_data0),
        .wr_data1_i (wr_data1),
        .wr_rdy_o   (wr_rdy),
        .rd_valid_o (rd_valid),
        .rd_data0_o (rd_data0),
        .rd_data1_o (rd_data1),
        .rd_rdy_i   (rd_rdy),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void checkValue(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic sbd_fifo_t mk(logic [31:0] pc);
        sbd_fifo_t e;
        e.pc = pc;
        e.pl = pc[6:2];
        return e;
    endfunction

    // Model: the FIFO is just a queue; acceptance decided from its size.
    always @(posedge clk or posedge rst) begin : model
        int sz;
        int nw;
        int nr;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            sz = model_q.size();
            nw = 0;
            nr = 0;
            if (wr_valid == 2'b11 && (Depth - sz) >= 2) nw = 2;
            else if (wr_valid[0] && (Depth - sz) >= 1) nw = 1;
            if (rd_rdy == 2'b11 && sz >= 2) nr = 2;
            else if (rd_rdy[0] && sz >= 1) nr = 1;
            for (int i = 0; i < nr; i++) void'(model_q.pop_front());
            if (nw >= 1) model_q.push_back(wr_data0);
            if (nw == 2) model_q.push_back(wr_data1);
        end
    end

    task automatic checkOutput();
        int sz;
        sz = model_q.size();
        checkValue("count", 64'(count), 64'(sz));
        checkValue("rd_valid", 64'(rd_valid), 64'({sz >= 2, sz >= 1}));
        checkValue("wr_rdy", 64'(wr_rdy), 64'({(Depth - sz) >= 2, (Depth - sz) >= 1}));
        checkValue("empty", 64'(empty), 64'(sz == 0));
        checkValue("full", 64'(full), 64'(sz == Depth));
        if (sz >= 1) checkValue("rd_data0", 64'(rd_data0), 64'(model_q[0]));
        if (sz >= 2) checkValue("rd_data1", 64'(rd_data1), 64'(model_q[1]));
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) checkOutput();
    end

    task automatic applyStimulus(input logic [1:0] wv, input sbd_fifo_t d0, input sbd_fifo_t d1,
                                 input logic [1:0] rr, input logic fl);
        wr_valid = wv;
        wr_data0 = d0;
        wr_data1 = d1;
        rd_rdy   = rr;
        flush    = fl;
        @(posedge clk);
        #1;
        wr_valid = 2'b00;
        rd_rdy   = 2'b00;
        flush    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        sbd_fifo_t a;
        sbd_fifo_t b;
        rst      = 1'b1;
        flush    = 1'b0;
        wr_valid = 2'b00;
        rd_rdy   = 2'b00;
        wr_data0 = '0;
        wr_data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkValue("reset rd_valid", 64'(rd_valid), 64'h0);
        checkValue("reset wr_rdy", 64'(wr_rdy), 64'h3);
        checkValue("reset count", 64'(count), 64'h0);
        checkValue("reset empty", 64'(empty), 64'h1);
        checkValue("reset full", 64'(full), 64'h0);
        checkValue("reset rd_data0", 64'(rd_data0), 64'h0);
        cmp_en = 1;

        // Dual enqueue then dual dequeue
        a.pc = 32'h100; a.pl = 5'b00010;
        b.pc = 32'h104; b.pl = 5'b00100;
        applyStimulus(2'b11, a, b, 2'b00, 1'b0);
        checkValue("dual rd_valid", 64'(rd_valid), 64'h3);
        checkValue("dual rd_data0.pc", 64'(rd_data0.pc), 64'h100);
        checkValue("dual rd_data1.pc", 64'(rd_data1.pc), 64'h104);
        checkValue("dual rd_data0.pl", 64'(rd_data0.pl), 64'h2);
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkValue("dual drained empty", 64'(empty), 64'h1);

        // Fill to 7, then near-full behaviour
        applyStimulus(2'b11, mk(32'h0),  mk(32'h4),  2'b00, 1'b0);
        applyStimulus(2'b11, mk(32'h8),  mk(32'hC),  2'b00, 1'b0);
        applyStimulus(2'b11, mk(32'h10), mk(32'h14), 2'b00, 1'b0);
        applyStimulus(2'b01, mk(32'h18), '0,         2'b00, 1'b0);
        checkValue("fill7 count", 64'(count), 64'd7);
        checkValue("fill7 wr_rdy", 64'(wr_rdy), 64'h1);
        applyStimulus(2'b11, mk(32'h1C), mk(32'h20), 2'b00, 1'b0);
        checkValue("nearfull count", 64'(count), 64'd8);
        checkValue("nearfull full", 64'(full), 64'h1);
        checkValue("nearfull wr_rdy", 64'(wr_rdy), 64'h0);
        applyStimulus(2'b01, mk(32'h24), '0, 2'b01, 1'b0);
        checkValue("full rd+wr count", 64'(count), 64'd7);
        checkValue("full rd+wr head", 64'(rd_data0.pc), 64'h4);

        // Continuous traffic across the pointer wrap
        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'b11, mk(32'h300 + 32'(8 * i)), mk(32'h304 + 32'(8 * i)),
                          (i % 3 == 0) ? 2'b11 : 2'b01, 1'b0);
        end
        repeat (5) applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkValue("drain empty", 64'(empty), 64'h1);

        // Flush priority
        applyStimulus(2'b11, mk(32'h400), mk(32'h404), 2'b00, 1'b0);
        applyStimulus(2'b11, mk(32'h408), mk(32'h40C), 2'b00, 1'b0);
        applyStimulus(2'b01, mk(32'h410), '0,          2'b00, 1'b0);
        checkValue("preflush count", 64'(count), 64'd5);
        applyStimulus(2'b11, mk(32'h600), mk(32'h604), 2'b11, 1'b1);
        checkValue("flush count", 64'(count), 64'h0);
        checkValue("flush rd_valid", 64'(rd_valid), 64'h0);
        checkValue("flush wr_rdy", 64'(wr_rdy), 64'h3);
        applyStimulus(2'b01, mk(32'h200), '0, 2'b00, 1'b0);
        checkValue("postflush head", 64'(rd_data0.pc), 64'h200);

        // Illegal masks are ignored
        applyStimulus(2'b11, mk(32'h204), mk(32'h208), 2'b00, 1'b0);
        checkValue("premask count", 64'(count), 64'd3);
        applyStimulus(2'b10, mk(32'h500), mk(32'h504), 2'b10, 1'b0);
        checkValue("mask count", 64'(count), 64'd3);
        checkValue("mask head", 64'(rd_data0.pc), 64'h200);

        // Reset asserted between clock edges clears immediately
        #2;
        rst = 1'b1;
        #1;
        checkValue("async rd_valid", 64'(rd_valid), 64'h0);
        checkValue("async wr_rdy", 64'(wr_rdy), 64'h3);
        checkValue("async count", 64'(count), 64'h0);
        checkValue("async empty", 64'(empty), 64'h1);
        rst = 1'b0;
        repeat (2) applyStimulus(2'b00, '0, '0, 2'b00, 1'b0);

        cmp_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
